// File: rtl/mic_sample_decimator_if.sv
// Sample-side and result-side signals of the microphone decimator.
// The slave modport is the decimator. The master modport is the mic core
// together with the consumer of averaged results.
interface mic_sample_decimator_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [17:0]      sample_in;
  logic             sample_rdy;
  logic             enable;
  logic [17:0]      avg_out;
  logic             avg_valid;
  logic             avg_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output sample_in, sample_rdy, enable, avg_ready, clr_overrun,
    input  avg_out, avg_valid, fifo_level, overrun
  );

  modport slave (
    input  sample_in, sample_rdy, enable, avg_ready, clr_overrun,
    output avg_out, avg_valid, fifo_level, overrun
  );
endinterface

// File: rtl/mic_sample_decimator.sv
// Boxcar decimator for 18-bit I2S microphone samples.
// Each new sample is detected on a 0->1 edge of the level drdy strobe and
// converted to two's complement. Blocks of 2**DECIM_LOG2 samples are summed,
// and the floor average is pushed into a small first-word-fall-through FIFO
// that has a valid/ready output.
module mic_sample_decimator #(
  parameter bit IN_OFFSET_BINARY = 1'b1,
  parameter int DECIM_LOG2       = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                 dclk,
  input  logic                 rst,
  mic_sample_decimator_if.slave bus
);

  localparam int DATA_W = 18;
  localparam int ACC_W  = DATA_W + DECIM_LOG2;
  localparam int CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [0:0]       ST_ACCUM = 1'b0;
  localparam logic [0:0]       ST_EMIT  = 1'b1;

  // Offset-binary input is turned into two's complement by flipping the MSB.
  function automatic logic signed [DATA_W-1:0] to_signed(input logic [DATA_W-1:0] raw);
    if (IN_OFFSET_BINARY) return {~raw[DATA_W-1], raw[DATA_W-2:0]};
    else                  return raw;
  endfunction

  // The arithmetic shift floors toward -inf. The result always fits in DATA_W bits.
  function automatic logic [DATA_W-1:0] avg_floor(input logic signed [ACC_W-1:0] total);
    logic signed [ACC_W-1:0] shifted;
    shifted = total >>> DECIM_LOG2;
    return shifted[DATA_W-1:0];
  endfunction

  logic                     rdy_q;
  logic                     acc_en;
  logic signed [DATA_W-1:0] s;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [0:0]               state_q, state_d;
  logic [DATA_W-1:0]        res_q, res_d;
  logic                     push;

  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [DATA_W-1:0]        avg_out_q, avg_out_d;
  logic                     overrun_q, overrun_d;
  logic                     valid, full, pop, wr_en, drop;

  assign s   = to_signed(bus.sample_in);
  assign sum = acc_q + ACC_W'(s);

  // Accept on a rising edge of drdy. Accumulate the sample, or close the block and request an emit.
  always_comb begin
    acc_en  = bus.enable & bus.sample_rdy & ~rdy_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    state_d = ST_ACCUM;
    if (!bus.enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_en) begin
      if (cnt_q == CNT_MAX) begin
        res_d   = avg_floor(sum);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_EMIT;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign push = (state_q == ST_EMIT);

  // Control and accumulator state. rdy_q resets high, so a strobe already held high is not taken as an edge.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_ACCUM;
    end else begin
      rdy_q   <= bus.sample_rdy;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Result register. It holds data only, and the EMIT cycle reads it.
  always_ff @(posedge dclk) begin
    res_q <= res_d;
  end

  // FIFO control. A push into a full FIFO succeeds only when a pop happens in the same cycle.
  always_comb begin
    valid    = (level_q != '0);
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    pop      = valid & bus.avg_ready;
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (level_d == '0)
      avg_out_d = '0;
    else if (wr_en && (wr_ptr_q == rd_ptr_d))
      avg_out_d = res_q;
    else
      avg_out_d = mem_q[rd_ptr_d];
    overrun_d = drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : overrun_q);
  end

  // FIFO pointers, level, registered head word and sticky overrun flag.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      avg_out_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      avg_out_q <= avg_out_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage. It has no reset, because the pointers alone decide what is valid.
  always_ff @(posedge dclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= res_q;
  end

  assign bus.avg_out    = avg_out_q;
  assign bus.avg_valid  = valid;
  assign bus.fifo_level = level_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mic_sample_decimator.sv
// Directed bench for mic_sample_decimator (offset input, DECIM_LOG2=2, FIFO_DEPTH=4).
module tb_mic_sample_decimator;

  logic dclk = 1'b0;
  logic rst;
  always #5 dclk = ~dclk;

  mic_sample_decimator_if #(.FIFO_DEPTH(4)) bus();

  mic_sample_decimator #(
    .IN_OFFSET_BINARY(1'b1),
    .DECIM_LOG2(2),
    .FIFO_DEPTH(4)
  ) dut (
    .dclk(dclk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic send(input logic [17:0] v);
    bus.sample_in  = v;
    bus.sample_rdy = 1'b1;
    step(1);
    bus.sample_rdy = 1'b0;
    step(1);
  endtask

  task automatic send4(input logic [17:0] v);
    repeat (4) send(v);
  endtask

  task automatic pop1;
    bus.avg_ready = 1'b1;
    step(1);
    bus.avg_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    bus.sample_in   = '0;
    bus.sample_rdy  = 1'b0;
    bus.enable      = 1'b1;
    bus.avg_ready   = 1'b0;
    bus.clr_overrun = 1'b0;
    step(2);
    check("rst_avg_out", bus.avg_out, 0);
    check("rst_valid",   bus.avg_valid, 0);
    check("rst_level",   bus.fifo_level, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    step(2);

    // Average of 4, 8, 12 and 16, with latency measured from the final accept
    send(18'h20004);
    send(18'h20008);
    send(18'h2000C);
    bus.sample_in  = 18'h20010;
    bus.sample_rdy = 1'b1;
    step(1);
    check("t1_valid_n1", bus.avg_valid, 0);
    bus.sample_rdy = 1'b0;
    step(1);
    check("t1_valid_n2", bus.avg_valid, 1);
    check("t1_avg",      bus.avg_out, 18'h0000A);
    check("t1_level",    bus.fifo_level, 1);
    pop1();
    check("t1_empty_valid", bus.avg_valid, 0);
    check("t1_empty_out",   bus.avg_out, 0);

    // Floor of -0.25 gives -1
    send(18'h1FFFF);
    send(18'h20000);
    send(18'h20000);
    send(18'h20000);
    check("t2_avg", bus.avg_out, 18'h3FFFF);
    pop1();

    // Full-scale positive and negative blocks must not wrap
    send4(18'h3FFFF);
    check("t3_max", bus.avg_out, 18'h1FFFF);
    pop1();
    send4(18'h00000);
    check("t3_min", bus.avg_out, 18'h20000);
    pop1();

    // Disabling discards a partial block. An EMIT already started still pushes.
    send(18'h20064);
    send(18'h20064);
    bus.enable = 1'b0;
    step(2);
    bus.enable = 1'b1;
    send(18'h20004);
    send(18'h20004);
    check("t6_no_early", bus.avg_valid, 0);
    send(18'h20008);
    bus.sample_in  = 18'h20008;
    bus.sample_rdy = 1'b1;
    step(1);
    bus.enable     = 1'b0;
    bus.sample_rdy = 1'b0;
    step(1);
    check("t6_emit_valid", bus.avg_valid, 1);
    check("t6_avg",        bus.avg_out, 18'h00006);
    bus.enable = 1'b1;
    pop1();

    // Fill the FIFO, drop two results, exercise the overrun flag, then drain in order
    for (int k = 1; k <= 4; k++) send4(18'h20000 + 18'(k));
    check("t4_level_full", bus.fifo_level, 4);
    check("t4_no_overrun", bus.overrun, 0);
    send4(18'h20005);
    check("t4_overrun",    bus.overrun, 1);
    check("t4_level_drop", bus.fifo_level, 4);
    send(18'h20006);
    send(18'h20006);
    send(18'h20006);
    bus.sample_in  = 18'h20006;
    bus.sample_rdy = 1'b1;
    step(1);
    bus.clr_overrun = 1'b1;
    bus.sample_rdy  = 1'b0;
    step(1);
    bus.clr_overrun = 1'b0;
    check("t6_clr_vs_drop", bus.overrun, 1);
    bus.clr_overrun = 1'b1;
    step(1);
    bus.clr_overrun = 1'b0;
    check("t4_clr", bus.overrun, 0);
    bus.avg_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t4_drain_valid", bus.avg_valid, 1);
      check("t4_drain_data",  bus.avg_out, 32'(k));
      step(1);
    end
    bus.avg_ready = 1'b0;
    check("t4_drained_valid", bus.avg_valid, 0);
    check("t4_drained_out",   bus.avg_out, 0);
    check("t4_drained_level", bus.fifo_level, 0);

    // Reset in mid-block with a result queued, strobe held high across the reset release
    send4(18'h20003);
    check("t5_pre_level", bus.fifo_level, 1);
    check("t5_pre_avg",   bus.avg_out, 18'h00003);
    send(18'h20100);
    send(18'h20100);
    bus.sample_in  = 18'h20190;
    bus.sample_rdy = 1'b1;
    step(1);
    rst = 1'b1;
    #1;
    check("t5_rst_out",     bus.avg_out, 0);
    check("t5_rst_valid",   bus.avg_valid, 0);
    check("t5_rst_level",   bus.fifo_level, 0);
    check("t5_rst_overrun", bus.overrun, 0);
    step(2);
    rst = 1'b0;
    step(3);
    check("t5_held_valid", bus.avg_valid, 0);
    bus.sample_rdy = 1'b0;
    step(1);
    bus.sample_in  = 18'h20008;
    bus.sample_rdy = 1'b1;
    step(3);
    bus.sample_rdy = 1'b0;
    step(1);
    send(18'h20008);
    send(18'h20008);
    check("t5_no_early", bus.avg_valid, 0);
    send(18'h20008);
    check("t5_valid", bus.avg_valid, 1);
    check("t5_avg",   bus.avg_out, 18'h00008);
    check("t5_level", bus.fifo_level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
